// File: rtl/fetch_seq_pkg.sv
// Shared types for the SAP-3 fetch/operand sequencer.
// State encodings, instruction length codes, strobe bundle.
package fetch_seq_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_F_ADDR  = 4'd1,
    S_F_RD    = 4'd2,
    S_DECODE  = 4'd3,
    S_O1_ADDR = 4'd4,
    S_O1_RD   = 4'd5,
    S_O2_ADDR = 4'd6,
    S_O2_RD   = 4'd7,
    S_X_START = 4'd8,
    S_X_WAIT  = 4'd9,
    S_HALTED  = 4'd10,
    S_FAULT   = 4'd11
  } state_e;

  typedef logic [1:0] ilen_t;

  localparam ilen_t LEN1 = 2'd1;
  localparam ilen_t LEN2 = 2'd2;
  localparam ilen_t LEN3 = 2'd3;

  localparam logic [7:0] HLT_OP = 8'h76;

  typedef struct packed {
    logic       pc_oe;
    logic       mar_we;
    logic       mem_oe;
    logic       ir_we;
    logic       pc_inc;
    logic [1:0] opr_we;
    logic       exec_start;
    logic       halted;
    logic       fault;
  } strb_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Memory/IR/execute-unit handshake bundle of the sequencer.
// master = sequencer side, slave = datapath side.
interface fetch_seq_if;

  logic [7:0] ir_in;
  logic [7:0] bus_in;
  logic       mem_ready;
  logic       exec_done;
  logic       pc_oe;
  logic       mar_we;
  logic       mem_oe;
  logic       ir_we;
  logic       pc_inc;
  logic [1:0] opr_we;
  logic       exec_start;

  modport master (
    input  ir_in,
    input  bus_in,
    input  mem_ready,
    input  exec_done,
    output pc_oe,
    output mar_we,
    output mem_oe,
    output ir_we,
    output pc_inc,
    output opr_we,
    output exec_start
  );

  modport slave (
    output ir_in,
    output bus_in,
    output mem_ready,
    output exec_done,
    input  pc_oe,
    input  mar_we,
    input  mem_oe,
    input  ir_we,
    input  pc_inc,
    input  opr_we,
    input  exec_start
  );

endinterface

// File: rtl/fetch_seq_ilen_decode.sv
// Opcode -> instruction length (1..3 bytes), 8085 subset.
// Pure combinational; the two multi-byte sets are disjoint.
module ilen_decode
  import fetch_seq_pkg::*;
(
  input  logic [7:0] opcode_i,
  output ilen_t      len_o
);

  logic is3;
  logic is2;

  assign is3 = ((opcode_i & 8'hCF) == 8'h01)
             || (opcode_i == 8'h3A)
             || (opcode_i == 8'h32)
             || (opcode_i == 8'h2A)
             || (opcode_i == 8'h22)
             || (opcode_i == 8'hC3)
             || (opcode_i == 8'hCD)
             || ((opcode_i & 8'hC7) == 8'hC2)
             || ((opcode_i & 8'hC7) == 8'hC4);

  assign is2 = ((opcode_i & 8'hC7) == 8'h06)
             || ((opcode_i & 8'hC7) == 8'hC6)
             || (opcode_i == 8'hDB)
             || (opcode_i == 8'hD3);

  // priority-free length select
  always_comb begin
    len_o = LEN1;
    unique case (1'b1)
      is3:     len_o = LEN3;
      is2:     len_o = LEN2;
      default: len_o = LEN1;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// SAP-3 fetch/operand sequencer with execute handoff.
// Moore strobes from state; read strobes gated by mem_ready.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [7:0] HLT_OPCODE   = HLT_OP,
  parameter int         EXEC_TIMEOUT = 16,
  parameter int         TO_W         = 5
) (
  input  logic         clk,
  input  logic         rst,
  fetch_seq_if.master  bus_if,
  output logic         halted_o,
  output logic         fault_o,
  output logic [3:0]   state_dbg_o
);

  state_e          state_q;
  state_e          state_d;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  ilen_t           len;
  logic            mr;
  logic            to_hit;
  strb_t           o;

  ilen_decode u_ilen (
    .opcode_i (bus_if.ir_in),
    .len_o    (len)
  );

  assign mr = bus_if.mem_ready;

  // a zero timeout turns the watchdog off
  assign to_hit = (EXEC_TIMEOUT != 0)
               && (cnt_q == TO_W'(EXEC_TIMEOUT - 1));

  // state and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state and watchdog count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RST:     state_d = S_F_ADDR;
      S_F_ADDR:  state_d = S_F_RD;
      S_F_RD:    if (mr) state_d = S_DECODE;
      S_DECODE: begin
        if (bus_if.ir_in == HLT_OPCODE)
          state_d = S_HALTED;
        else if (len == LEN1)
          state_d = S_X_START;
        else
          state_d = S_O1_ADDR;
      end
      S_O1_ADDR: state_d = S_O1_RD;
      S_O1_RD: begin
        if (mr)
          state_d = (len == LEN3) ? S_O2_ADDR
                                  : S_X_START;
      end
      S_O2_ADDR: state_d = S_O2_RD;
      S_O2_RD:   if (mr) state_d = S_X_START;
      S_X_START: begin
        cnt_d   = '0;
        state_d = S_X_WAIT;
      end
      S_X_WAIT: begin
        if (bus_if.exec_done) begin
          state_d = S_F_ADDR;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (to_hit) state_d = S_FAULT;
        end
      end
      S_HALTED:  state_d = S_HALTED;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_RST;
    endcase
  end

  // strobes decoded from state only, plus ready gating
  always_comb begin
    o = '0;
    unique case (state_q)
      S_F_ADDR, S_O1_ADDR, S_O2_ADDR: begin
        o.pc_oe  = 1'b1;
        o.mar_we = 1'b1;
      end
      S_F_RD: begin
        o.mem_oe = 1'b1;
        o.ir_we  = mr;
        o.pc_inc = mr;
      end
      S_O1_RD: begin
        o.mem_oe    = 1'b1;
        o.opr_we[0] = mr;
        o.pc_inc    = mr;
      end
      S_O2_RD: begin
        o.mem_oe    = 1'b1;
        o.opr_we[1] = mr;
        o.pc_inc    = mr;
      end
      S_X_START: o.exec_start = 1'b1;
      S_HALTED:  o.halted     = 1'b1;
      S_FAULT:   o.fault      = 1'b1;
      default:   o = '0;
    endcase
  end

  assign bus_if.pc_oe      = o.pc_oe;
  assign bus_if.mar_we     = o.mar_we;
  assign bus_if.mem_oe     = o.mem_oe;
  assign bus_if.ir_we      = o.ir_we;
  assign bus_if.pc_inc     = o.pc_inc;
  assign bus_if.opr_we     = o.opr_we;
  assign bus_if.exec_start = o.exec_start;
  assign halted_o          = o.halted;
  assign fault_o           = o.fault;
  assign state_dbg_o       = state_q;

endmodule
